// File: rtl/dnpcie_aurora_pkg.sv
// Shared types and helpers for the Aurora link monitor: state encoding,
// bus widths and saturating counter increments.
package dnpcie_aurora_pkg;

    localparam int unsigned HP_W    = 48;
    localparam int unsigned TIMER_W = 32;
    localparam int unsigned FAIL_W  = 4;
    localparam int unsigned RCNT_W  = 16;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WAIT_UP  = 3'd1,
        ST_UP       = 3'd2,
        ST_DEBOUNCE = 3'd3,
        ST_REQ      = 3'd4,
        ST_BUSY     = 3'd5
    } state_t;

    function automatic logic [FAIL_W-1:0] sat_inc_fail(input logic [FAIL_W-1:0] v);
        return (&v) ? v : v + FAIL_W'(1);
    endfunction

    function automatic logic [RCNT_W-1:0] sat_inc_rcnt(input logic [RCNT_W-1:0] v);
        return (&v) ? v : v + RCNT_W'(1);
    endfunction

endpackage

// File: rtl/dnpcie_aurora_backoff.sv
// Exponential back-off for the sequencer hotplug wait: base << min(fail, max_shift),
// saturating at all-ones; the register only loads when a reset request is issued.
module dnpcie_aurora_backoff
    import dnpcie_aurora_pkg::*;
#(
    parameter longint unsigned HP_WAIT_BASE = 64'd200000000,
    parameter int unsigned     MAX_SHIFT    = 4
)(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [FAIL_W-1:0] fail_count,
    output logic [HP_W-1:0]   hotplug_wait
);

    localparam logic [HP_W-1:0] BASE = HP_W'(HP_WAIT_BASE);

    logic [FAIL_W-1:0] shift_amt;
    logic [2*HP_W-1:0] wide;
    logic [HP_W-1:0]   wait_val;

    // Shift in double width so any bit pushed past 48 flags overflow.
    always_comb begin
        shift_amt = fail_count;
        if (32'(fail_count) > MAX_SHIFT) begin
            shift_amt = FAIL_W'(MAX_SHIFT);
        end
        wide     = {{HP_W{1'b0}}, BASE} << shift_amt;
        wait_val = (|wide[2*HP_W-1:HP_W]) ? {HP_W{1'b1}} : wide[HP_W-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hotplug_wait <= BASE;
        end else if (load) begin
            hotplug_wait <= wait_val;
        end
    end

endmodule

// File: rtl/dnpcie_aurora_link_monitor.sv
// Aurora link supervisor: watches channel_up and sequencer busy, issues ext_reset
// on bring-up timeout, debounced link drop or software force, with back-off.
module dnpcie_aurora_link_monitor
    import dnpcie_aurora_pkg::*;
#(
    parameter int unsigned     LINK_TIMEOUT  = 400000000,
    parameter int unsigned     DROP_DEBOUNCE = 2000,
    parameter longint unsigned HP_WAIT_BASE  = 64'd200000000,
    parameter int unsigned     MAX_SHIFT     = 4
)(
    input  logic              init_clk,
    input  logic              init_rst_n,
    input  logic              channel_up_i,
    input  logic              reset_busy_i,
    input  logic              force_reset_i,
    output logic              link_reset_o,
    output logic [HP_W-1:0]   hotplug_wait_o,
    output logic              link_ok_o,
    output logic [FAIL_W-1:0] fail_count_o,
    output logic [RCNT_W-1:0] reset_count_o
);

    localparam logic [TIMER_W-1:0] TIMEOUT_LAST = TIMER_W'(LINK_TIMEOUT - 1);
    // The UP cycle that sees the first low sample counts toward the debounce,
    // so the timer value on the last low sample is DROP_DEBOUNCE-2.
    localparam logic [TIMER_W-1:0] DEB_LAST = (DROP_DEBOUNCE >= 2) ?
                                              TIMER_W'(DROP_DEBOUNCE - 2) : '0;
    localparam bit DEB_IMMEDIATE = (DROP_DEBOUNCE <= 1);

    (* async_reg = "true" *) logic cu_meta;
    (* async_reg = "true" *) logic cu;

    state_t              state;
    state_t              state_next;
    logic [TIMER_W-1:0]  timer;
    logic                timer_run;
    logic [FAIL_W-1:0]   fail_next;
    logic                req_entry;

    always_ff @(posedge init_clk or negedge init_rst_n) begin
        if (!init_rst_n) begin
            cu_meta <= 1'b0;
            cu      <= 1'b0;
        end else begin
            cu_meta <= channel_up_i;
            cu      <= cu_meta;
        end
    end

    always_ff @(posedge init_clk or negedge init_rst_n) begin
        if (!init_rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        fail_next  = fail_count_o;
        timer_run  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!reset_busy_i) state_next = ST_WAIT_UP;
            end
            ST_WAIT_UP: begin
                timer_run = 1'b1;
                if (cu) begin
                    state_next = ST_UP;
                    fail_next  = '0;
                end else if (timer == TIMEOUT_LAST) begin
                    state_next = ST_REQ;
                    fail_next  = sat_inc_fail(fail_count_o);
                end
            end
            ST_UP: begin
                if (reset_busy_i)  state_next = ST_BUSY;
                else if (!cu)      state_next = DEB_IMMEDIATE ? ST_REQ : ST_DEBOUNCE;
            end
            ST_DEBOUNCE: begin
                timer_run = 1'b1;
                if (reset_busy_i)           state_next = ST_BUSY;
                else if (cu)                state_next = ST_UP;
                else if (timer == DEB_LAST) state_next = ST_REQ;
            end
            ST_REQ: begin
                if (reset_busy_i) state_next = ST_BUSY;
            end
            ST_BUSY: begin
                if (!reset_busy_i) state_next = ST_WAIT_UP;
            end
            default: state_next = ST_IDLE;
        endcase
        // Software force overrides every other transition outside REQ/BUSY.
        if (force_reset_i && (state != ST_REQ) && (state != ST_BUSY)) begin
            state_next = ST_REQ;
            fail_next  = fail_count_o;
        end
        req_entry = (state_next == ST_REQ) && (state != ST_REQ);
    end

    always_ff @(posedge init_clk or negedge init_rst_n) begin
        if (!init_rst_n) begin
            timer         <= '0;
            link_reset_o  <= 1'b0;
            link_ok_o     <= 1'b0;
            fail_count_o  <= '0;
            reset_count_o <= '0;
        end else begin
            if (state_next != state) timer <= '0;
            else if (timer_run)      timer <= timer + TIMER_W'(1);
            link_reset_o  <= (state_next == ST_REQ);
            link_ok_o     <= (state_next == ST_UP);
            fail_count_o  <= fail_next;
            if (req_entry) reset_count_o <= sat_inc_rcnt(reset_count_o);
        end
    end

    dnpcie_aurora_backoff #(
        .HP_WAIT_BASE (HP_WAIT_BASE),
        .MAX_SHIFT    (MAX_SHIFT)
    ) u_backoff (
        .clk          (init_clk),
        .rst_n        (init_rst_n),
        .load         (req_entry),
        .fail_count   (fail_next),
        .hotplug_wait (hotplug_wait_o)
    );

endmodule

// File: tb/tb_dnpcie_aurora_link_monitor.sv
// Directed bench for the Aurora link monitor with a simple sequencer model;
// each ext_reset rise is scored against an expected hotplug/fail/reset tuple.
module tb_dnpcie_aurora_link_monitor;

    localparam int unsigned     LINK_TIMEOUT  = 100;
    localparam int unsigned     DROP_DEBOUNCE = 8;
    localparam longint unsigned HP_WAIT_BASE  = 64'd1000;
    localparam int unsigned     MAX_SHIFT     = 2;

    logic        init_clk = 1'b0;
    logic        init_rst_n;
    logic        channel_up;
    logic        force_reset;
    logic        man_busy;
    logic        seq_busy;
    logic        reset_busy;
    logic        link_reset;
    logic [47:0] hotplug_wait;
    logic        link_ok;
    logic [3:0]  fail_count;
    logic [15:0] reset_count;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [47:0] hp;
        logic [3:0]  fc;
        logic [15:0] rc;
    } exp_t;
    exp_t sb_q[$];

    bit   seq_en  = 1'b1;
    int   seq_dly = 0;
    int   seq_cnt = 0;
    logic mon_prev;

    assign reset_busy = seq_busy | man_busy;

    always #5 init_clk = ~init_clk;

    dnpcie_aurora_link_monitor #(
        .LINK_TIMEOUT  (LINK_TIMEOUT),
        .DROP_DEBOUNCE (DROP_DEBOUNCE),
        .HP_WAIT_BASE  (HP_WAIT_BASE),
        .MAX_SHIFT     (MAX_SHIFT)
    ) dut (
        .init_clk       (init_clk),
        .init_rst_n     (init_rst_n),
        .channel_up_i   (channel_up),
        .reset_busy_i   (reset_busy),
        .force_reset_i  (force_reset),
        .link_reset_o   (link_reset),
        .hotplug_wait_o (hotplug_wait),
        .link_ok_o      (link_ok),
        .fail_count_o   (fail_count),
        .reset_count_o  (reset_count)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge init_clk);
        #1;
    endtask

    task automatic push_exp(input logic [47:0] hp, input logic [3:0] fc, input logic [15:0] rc);
        exp_t e;
        e.hp = hp;
        e.fc = fc;
        e.rc = rc;
        sb_q.push_back(e);
    endtask

    task automatic wait_reset_level(input logic val, input int max, input string tag, output int n);
        n = 0;
        while (link_reset !== val && n < max) begin
            tick(1);
            n++;
        end
        chk(tag, 64'(link_reset), 64'(val));
    endtask

    task automatic wait_ok(input int max, input string tag);
        int n = 0;
        while (link_ok !== 1'b1 && n < max) begin
            tick(1);
            n++;
        end
        chk(tag, 64'(link_ok), 64'(1));
    endtask

    // Sequencer model: busy rises 2 cycles after ext_reset is seen, held 50 cycles.
    always begin
        @(posedge init_clk);
        #1;
        if (!seq_en) begin
            seq_dly  = 0;
            seq_cnt  = 0;
            seq_busy = 1'b0;
        end else if (seq_cnt > 0) begin
            seq_cnt--;
            if (seq_cnt == 0) seq_busy = 1'b0;
        end else if (seq_dly > 0) begin
            seq_dly--;
            if (seq_dly == 0) begin
                seq_busy = 1'b1;
                seq_cnt  = 50;
            end
        end else if (link_reset === 1'b1) begin
            seq_dly = 2;
        end
    end

    // Scoreboard: every ext_reset rise must match the next queued expectation.
    always begin
        @(posedge init_clk);
        #1;
        if (link_reset === 1'b1 && mon_prev !== 1'b1) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_reset", 64'(link_reset), 64'(0));
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("sb_hotplug", 64'(hotplug_wait), 64'(e.hp));
                chk("sb_fail_count", 64'(fail_count), 64'(e.fc));
                chk("sb_reset_count", 64'(reset_count), 64'(e.rc));
            end
        end
        mon_prev = link_reset;
    end

    initial begin
        int n;
        int n1;
        int n2;
        init_rst_n  = 1'b0;
        channel_up  = 1'b0;
        force_reset = 1'b0;
        man_busy    = 1'b0;
        seq_busy    = 1'b0;
        tick(3);
        chk("rst_link_reset", 64'(link_reset), 64'(0));
        chk("rst_link_ok", 64'(link_ok), 64'(0));
        chk("rst_fail_count", 64'(fail_count), 64'(0));
        chk("rst_reset_count", 64'(reset_count), 64'(0));
        chk("rst_hotplug", 64'(hotplug_wait), 64'(1000));

        // Bring-up: channel_up 20 cycles after release, link_ok 3 cycles later.
        init_rst_n = 1'b1;
        tick(20);
        channel_up = 1'b1;
        tick(2);
        chk("link_ok_early", 64'(link_ok), 64'(0));
        tick(1);
        chk("link_ok_rise", 64'(link_ok), 64'(1));
        chk("up_no_reset", 64'(link_reset), 64'(0));
        chk("up_fail_count", 64'(fail_count), 64'(0));

        // 7-cycle dropout must be absorbed.
        tick(5);
        channel_up = 1'b0;
        tick(7);
        chk("debounce_entered", 64'(link_ok), 64'(0));
        channel_up = 1'b1;
        tick(12);
        chk("glitch7_still_up", 64'(link_ok), 64'(1));
        chk("glitch7_no_count", 64'(reset_count), 64'(0));

        // 8-cycle dropout triggers one request.
        push_exp(48'd1000, 4'd0, 16'd1);
        channel_up = 1'b0;
        tick(8);
        channel_up = 1'b1;
        wait_reset_level(1'b1, 20, "drop8_reset", n);
        chk("drop8_latency", 64'(n), 64'(2));
        wait_reset_level(1'b0, 10, "drop8_release", n);
        wait_ok(100, "drop8_recover");
        chk("drop8_reset_count", 64'(reset_count), 64'(1));

        // Forced reset in UP: level held until busy is sampled.
        tick(3);
        push_exp(48'd1000, 4'd0, 16'd2);
        force_reset = 1'b1;
        tick(1);
        force_reset = 1'b0;
        chk("force_rise", 64'(link_reset), 64'(1));
        tick(1);
        chk("force_hold1", 64'(link_reset), 64'(1));
        tick(1);
        chk("force_hold2", 64'(link_reset), 64'(1));
        tick(1);
        chk("force_fall", 64'(link_reset), 64'(0));
        chk("force_fail_unchanged", 64'(fail_count), 64'(0));
        wait_ok(100, "force_recover");

        // Channel stays down: one drop request then four timeouts with back-off.
        tick(3);
        push_exp(48'd1000, 4'd0, 16'd3);
        push_exp(48'd2000, 4'd1, 16'd4);
        push_exp(48'd4000, 4'd2, 16'd5);
        push_exp(48'd4000, 4'd3, 16'd6);
        push_exp(48'd4000, 4'd4, 16'd7);
        channel_up = 1'b0;
        wait_reset_level(1'b1, 30, "dead_drop_reset", n);
        for (int k = 0; k < 4; k++) begin
            wait_reset_level(1'b0, 10, "timeout_release", n1);
            wait_reset_level(1'b1, 300, "timeout_reset", n2);
            chk("timeout_interval", 64'(n1 + n2), 64'(153));
        end
        channel_up = 1'b1;
        wait_ok(100, "dead_recover");
        chk("recover_fail_cleared", 64'(fail_count), 64'(0));
        chk("recover_hotplug_held", 64'(hotplug_wait), 64'(4000));
        chk("recover_reset_count", 64'(reset_count), 64'(7));

        // Sequencer busy from elsewhere while UP: no request issued.
        tick(3);
        man_busy = 1'b1;
        tick(1);
        chk("spont_busy_ok_low", 64'(link_ok), 64'(0));
        chk("spont_busy_no_reset", 64'(link_reset), 64'(0));
        tick(4);
        man_busy = 1'b0;
        tick(1);
        chk("spont_wait_up", 64'(link_ok), 64'(0));
        tick(1);
        chk("spont_back_up", 64'(link_ok), 64'(1));
        chk("spont_reset_count", 64'(reset_count), 64'(7));

        // Reset asserted while in REQ clears everything at once.
        seq_en = 1'b0;
        tick(2);
        push_exp(48'd1000, 4'd0, 16'd8);
        force_reset = 1'b1;
        tick(1);
        force_reset = 1'b0;
        tick(3);
        chk("req_held_no_busy", 64'(link_reset), 64'(1));
        init_rst_n = 1'b0;
        #1;
        chk("async_link_reset", 64'(link_reset), 64'(0));
        chk("async_link_ok", 64'(link_ok), 64'(0));
        chk("async_fail_count", 64'(fail_count), 64'(0));
        chk("async_reset_count", 64'(reset_count), 64'(0));
        chk("async_hotplug", 64'(hotplug_wait), 64'(1000));
        tick(2);
        init_rst_n = 1'b1;
        seq_en     = 1'b1;
        wait_ok(20, "post_reset_up");
        chk("post_reset_count", 64'(reset_count), 64'(0));
        tick(5);
        chk("sb_drained", 64'(sb_q.size()), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
